// File: rtl/row_select_encoder.sv
// row_select_encoder: folds 16 row request lines back into a
// registered 4-bit address stream with a valid/ready handshake.
module row_select_encoder #(
    parameter bit         ROUND_ROBIN = 1'b1,
    parameter logic [3:0] RESET_PTR   = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req_in,
    input  logic        flush,
    output logic [3:0]  addr_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [4:0]  pending_count,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic [3:0]  addr_q, addr_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        accept;
    logic [15:0] grant_mask;
    logic [15:0] pend_nxt;
    logic [4:0]  pend_pop;
    logic [3:0]  base;
    logic [3:0]  idx;
    logic [3:0]  sel;
    logic        sel_vld;

    assign valid_out     = (state_q == OFFER);
    assign addr_out      = addr_q;
    assign pending_count = cnt_q;
    assign busy          = (|pend_q) | valid_out;

    // Retire the accepted row, then OR in new requests so set wins.
    always_comb begin
        accept     = valid_out && ready_in;
        grant_mask = accept ? (16'd1 << addr_q) : 16'd0;
        pend_nxt   = (pend_q & ~grant_mask) | req_in;
        pend_pop   = 5'd0;
        for (int i = 0; i < 16; i++) begin
            pend_pop = pend_pop + {4'd0, pend_nxt[i]};
        end
    end

    // Pick the next row: rotating from the pointer, or lowest index.
    always_comb begin
        if (!ROUND_ROBIN) begin
            base = 4'd0;
        end else if (accept) begin
            base = addr_q + 4'd1;
        end else begin
            base = ptr_q;
        end
        idx     = 4'd0;
        sel     = 4'd0;
        sel_vld = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = base + 4'(i);
            if (!sel_vld && pend_nxt[idx]) begin
                sel     = idx;
                sel_vld = 1'b1;
            end
        end
    end

    // Offer FSM next state; flush overrides any accept or request.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        pend_d  = pend_nxt;
        cnt_d   = pend_pop;
        if (flush) begin
            state_d = IDLE;
            pend_d  = 16'd0;
            cnt_d   = 5'd0;
            ptr_d   = RESET_PTR;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        state_d = OFFER;
                        addr_d  = sel;
                    end
                end
                OFFER: begin
                    if (accept) begin
                        if (ROUND_ROBIN) begin
                            ptr_d = addr_q + 4'd1;
                        end
                        if (sel_vld) begin
                            addr_d = sel;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, pending set, offered address, pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 16'd0;
            addr_q  <= 4'd0;
            ptr_q   <= RESET_PTR;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_row_select_encoder.sv
// Bench for row_select_encoder: round-robin and fixed-priority
// instances, accepted addresses scored against an expected queue.
module tb_row_select_encoder;

    logic        clk;
    logic        rst_n;

    logic [15:0] req_r, req_f;
    logic        flush_r, flush_f;
    logic        rdy_r, rdy_f;
    logic [3:0]  addr_r, addr_f;
    logic        vld_r, vld_f;
    logic [4:0]  cnt_r, cnt_f;
    logic        busy_r, busy_f;

    int n_chk;
    int n_pass;

    logic [3:0] q_r[$];
    logic [3:0] q_f[$];

    row_select_encoder #(.ROUND_ROBIN(1'b1), .RESET_PTR(4'd0)) u_rr (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_in        (req_r),
        .flush         (flush_r),
        .addr_out      (addr_r),
        .valid_out     (vld_r),
        .ready_in      (rdy_r),
        .pending_count (cnt_r),
        .busy          (busy_r)
    );

    row_select_encoder #(.ROUND_ROBIN(1'b0), .RESET_PTR(4'd0)) u_fx (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_in        (req_f),
        .flush         (flush_f),
        .addr_out      (addr_f),
        .valid_out     (vld_f),
        .ready_in      (rdy_f),
        .pending_count (cnt_f),
        .busy          (busy_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Score every accepted address against the expected queue.
    always @(negedge clk) begin
        if (rst_n && vld_r && rdy_r && !flush_r) begin
            if (q_r.size() == 0) chk("rr_unexpected", {28'd0, addr_r}, 32'hFFFF);
            else chk("rr_accept", {28'd0, addr_r}, {28'd0, q_r.pop_front()});
        end
        if (rst_n && vld_f && rdy_f && !flush_f) begin
            if (q_f.size() == 0) chk("fx_unexpected", {28'd0, addr_f}, 32'hFFFF);
            else chk("fx_accept", {28'd0, addr_f}, {28'd0, q_f.pop_front()});
        end
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        req_r = '0; req_f = '0;
        flush_r = 1'b0; flush_f = 1'b0;
        rdy_r = 1'b0; rdy_f = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, vld_r}, 0);
        chk("rst_addr", {28'd0, addr_r}, 0);
        chk("rst_cnt", {27'd0, cnt_r}, 0);
        chk("rst_busy", {31'd0, busy_r}, 0);
        rst_n = 1'b1;
        cyc();

        // single request, single accept
        req_r = 16'h0001;
        cyc();
        req_r = '0;
        chk("t1_valid", {31'd0, vld_r}, 1);
        chk("t1_addr", {28'd0, addr_r}, 0);
        chk("t1_cnt", {27'd0, cnt_r}, 1);
        q_r.push_back(4'd0);
        rdy_r = 1'b1;
        cyc();
        rdy_r = 1'b0;
        chk("t1_valid_done", {31'd0, vld_r}, 0);
        chk("t1_cnt_done", {27'd0, cnt_r}, 0);
        chk("t1_busy_done", {31'd0, busy_r}, 0);

        // flush restores pointer to 0, then round-robin sweep
        flush_r = 1'b1;
        cyc();
        flush_r = 1'b0;
        q_r.push_back(4'd0); q_r.push_back(4'd5);
        q_r.push_back(4'd10); q_r.push_back(4'd15);
        req_r = 16'h8421;
        rdy_r = 1'b1;
        cyc();
        req_r = '0;
        chk("t2_a0", {28'd0, addr_r}, 0);
        chk("t2_c0", {27'd0, cnt_r}, 4);
        cyc();
        chk("t2_a1", {28'd0, addr_r}, 5);
        chk("t2_v1", {31'd0, vld_r}, 1);
        cyc();
        chk("t2_a2", {28'd0, addr_r}, 10);
        cyc();
        chk("t2_a3", {28'd0, addr_r}, 15);
        chk("t2_c3", {27'd0, cnt_r}, 1);
        cyc();
        chk("t2_vend", {31'd0, vld_r}, 0);
        q_r.push_back(4'd0); q_r.push_back(4'd5);
        req_r = 16'h0021;
        cyc();
        req_r = '0;
        chk("t2_wrap0", {28'd0, addr_r}, 0);
        cyc();
        chk("t2_wrap5", {28'd0, addr_r}, 5);
        cyc();
        chk("t2_wrap_end", {31'd0, vld_r}, 0);
        rdy_r = 1'b0;

        // set wins over accept on the same row
        req_r = 16'h0008;
        cyc();
        req_r = '0;
        chk("t4_addr", {28'd0, addr_r}, 3);
        chk("t4_cnt", {27'd0, cnt_r}, 1);
        q_r.push_back(4'd3);
        rdy_r = 1'b1;
        req_r = 16'h0008;
        cyc();
        rdy_r = 1'b0;
        req_r = '0;
        chk("t4_again_v", {31'd0, vld_r}, 1);
        chk("t4_again_a", {28'd0, addr_r}, 3);
        chk("t4_again_c", {27'd0, cnt_r}, 1);
        q_r.push_back(4'd3);
        rdy_r = 1'b1;
        cyc();
        rdy_r = 1'b0;
        chk("t4_done", {31'd0, vld_r}, 0);

        // stalled offer holds while new requests accumulate
        req_r = 16'h0080;
        cyc();
        req_r = '0;
        chk("t5_addr", {28'd0, addr_r}, 7);
        chk("t5_cnt1", {27'd0, cnt_r}, 1);
        for (int i = 0; i < 10; i++) begin
            req_r = (i == 3) ? 16'h0002 : 16'h0000;
            cyc();
            chk("t5_hold_a", {28'd0, addr_r}, 7);
            chk("t5_hold_v", {31'd0, vld_r}, 1);
        end
        req_r = '0;
        chk("t5_cnt2", {27'd0, cnt_r}, 2);
        q_r.push_back(4'd7); q_r.push_back(4'd1);
        rdy_r = 1'b1;
        cyc();
        chk("t5_next", {28'd0, addr_r}, 1);
        cyc();
        rdy_r = 1'b0;
        chk("t5_end", {31'd0, vld_r}, 0);

        // full request set, then flush racing an accept
        req_r = 16'hFFFF;
        cyc();
        req_r = '0;
        chk("t6_cnt16", {27'd0, cnt_r}, 16);
        chk("t6_valid", {31'd0, vld_r}, 1);
        flush_r = 1'b1;
        rdy_r = 1'b1;
        req_r = 16'h0100;
        cyc();
        flush_r = 1'b0;
        rdy_r = 1'b0;
        req_r = '0;
        chk("t6_fl_valid", {31'd0, vld_r}, 0);
        chk("t6_fl_cnt", {27'd0, cnt_r}, 0);
        chk("t6_fl_busy", {31'd0, busy_r}, 0);

        // fixed priority: lower new request overtakes
        req_f = 16'h0030;
        cyc();
        req_f = '0;
        chk("t3_addr4", {28'd0, addr_f}, 4);
        chk("t3_cnt2", {27'd0, cnt_f}, 2);
        q_f.push_back(4'd4);
        rdy_f = 1'b1;
        req_f = 16'h0001;
        cyc();
        req_f = '0;
        q_f.push_back(4'd0); q_f.push_back(4'd5);
        chk("t3_addr0", {28'd0, addr_f}, 0);
        cyc();
        chk("t3_addr5", {28'd0, addr_f}, 5);
        cyc();
        rdy_f = 1'b0;
        chk("t3_end", {31'd0, vld_f}, 0);

        // fixed priority: full drain one row per cycle
        req_f = 16'hFFFF;
        cyc();
        req_f = '0;
        for (int i = 0; i < 16; i++) q_f.push_back(4'(i));
        rdy_f = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("dr_addr", {28'd0, addr_f}, i);
            chk("dr_cnt", {27'd0, cnt_f}, 16 - i);
            cyc();
        end
        rdy_f = 1'b0;
        chk("dr_valid", {31'd0, vld_f}, 0);
        chk("dr_busy", {31'd0, busy_f}, 0);

        // asynchronous reset drops a live offer
        req_r = 16'h0010;
        cyc();
        req_r = '0;
        chk("t7_valid", {31'd0, vld_r}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_async_v", {31'd0, vld_r}, 0);
        chk("t7_async_c", {27'd0, cnt_r}, 0);
        chk("t7_async_b", {31'd0, busy_r}, 0);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("t7_after_v", {31'd0, vld_r}, 0);
        chk("t7_after_b", {31'd0, busy_r}, 0);

        chk("rr_q_empty", q_r.size(), 0);
        chk("fx_q_empty", q_f.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
